// File: rtl/rcc_dom_rst_clk_seq_if.sv
// Control/status bundle between the RCC vcore domain sequencer and its neighbours
// (system clock/reset controller and register file).
interface rcc_dom_rst_clk_seq_if;
  logic pwr_rdy;
  logic sw_rst_req;
  logic stop_req;
  logic rst_flag_clr;
  logic dom_rst_n;
  logic dom_clk_en;
  logic dom_rdy;
  logic busy;
  logic rst_flag;

  modport master (
    output pwr_rdy, sw_rst_req, stop_req, rst_flag_clr,
    input  dom_rst_n, dom_clk_en, dom_rdy, busy, rst_flag
  );

  modport slave (
    input  pwr_rdy, sw_rst_req, stop_req, rst_flag_clr,
    output dom_rst_n, dom_clk_en, dom_rdy, busy, rst_flag
  );
endinterface

// File: rtl/rcc_dom_rst_clk_seq.sv
// Per-domain reset/clock sequencer: hold reset, release, delay, enable clock;
// stop-mode gating with retention and immediate shutdown on power loss.
//
// state    | meaning
// ---------+------------------------------------------------------------
// OFF      | no domain power; reset asserted, clock gated
// RST_HOLD | domain reset held for RST_DURATION cycles
// CLK_WAIT | reset released, waiting CLK_ON_DELAY cycles before clock on
// RUN      | domain out of reset and clocked
// STOP     | clock gated, reset released, domain state retained
module rcc_dom_rst_clk_seq #(
  parameter int RST_DURATION = 10,
  parameter int CLK_ON_DELAY = 8,
  parameter int CNT_W        = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rcc_dom_rst_clk_seq_if.slave dom
);

  typedef enum logic [2:0] {
    OFF      = 3'd0,
    RST_HOLD = 3'd1,
    CLK_WAIT = 3'd2,
    RUN      = 3'd3,
    STOP     = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(RST_DURATION - 1);
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(CLK_ON_DELAY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rst_n_q, rst_n_d;
  logic             clk_en_q, clk_en_d;
  logic             rdy_q, rdy_d;
  logic             busy_q, busy_d;
  logic             flag_q, flag_d;
  logic             hold_entry;

  // Next state and counter; power loss outranks everything, then sw reset.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!dom.pwr_rdy) begin
      state_d = OFF;
      cnt_d   = '0;
    end else begin
      case (state_q)
        OFF: begin
          state_d = RST_HOLD;
          cnt_d   = HOLD_LOAD;
        end
        RST_HOLD: begin
          if (dom.sw_rst_req) begin
            cnt_d = HOLD_LOAD;
          end else if (cnt_q == '0) begin
            state_d = CLK_WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        CLK_WAIT: begin
          if (dom.sw_rst_req) begin
            state_d = RST_HOLD;
            cnt_d   = HOLD_LOAD;
          end else if (cnt_q == '0) begin
            state_d = RUN;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        RUN: begin
          if (dom.sw_rst_req) begin
            state_d = RST_HOLD;
            cnt_d   = HOLD_LOAD;
          end else if (dom.stop_req) begin
            state_d = STOP;
          end
        end
        STOP: begin
          if (dom.sw_rst_req) begin
            state_d = RST_HOLD;
            cnt_d   = HOLD_LOAD;
          end else if (!dom.stop_req) begin
            state_d = RUN;
          end
        end
        default: begin
          state_d = OFF;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // A restart inside RST_HOLD counts as a new sequence for the sticky flag.
  assign hold_entry = (state_d == RST_HOLD) &&
                      ((state_q != RST_HOLD) || dom.sw_rst_req);

  always_comb begin
    rst_n_d  = 1'b0;
    clk_en_d = 1'b0;
    rdy_d    = 1'b0;
    busy_d   = 1'b0;
    case (state_d)
      RST_HOLD: busy_d = 1'b1;
      CLK_WAIT: begin
        rst_n_d = 1'b1;
        busy_d  = 1'b1;
      end
      RUN: begin
        rst_n_d  = 1'b1;
        clk_en_d = 1'b1;
        rdy_d    = 1'b1;
      end
      STOP:    rst_n_d = 1'b1;
      default: rst_n_d = 1'b0;
    endcase
  end

  always_comb begin
    flag_d = flag_q;
    if (dom.rst_flag_clr) flag_d = 1'b0;
    if (hold_entry)       flag_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= OFF;
      cnt_q    <= '0;
      rst_n_q  <= 1'b0;
      clk_en_q <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rst_n_q  <= rst_n_d;
      clk_en_q <= clk_en_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
      flag_q   <= flag_d;
    end
  end

  assign dom.dom_rst_n  = rst_n_q;
  assign dom.dom_clk_en = clk_en_q;
  assign dom.dom_rdy    = rdy_q;
  assign dom.busy       = busy_q;
  assign dom.rst_flag   = flag_q;

endmodule

// File: tb/tb_rcc_dom_rst_clk_seq.sv
// Scoreboard bench for rcc_dom_rst_clk_seq: stimulus queues expected output
// vectors {dom_rst_n, dom_clk_en, dom_rdy, busy, rst_flag} keyed by clock edge.
module tb_rcc_dom_rst_clk_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rcc_dom_rst_clk_seq_if bus ();

  rcc_dom_rst_clk_seq #(
    .RST_DURATION(10),
    .CLK_ON_DELAY(8),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .dom(bus)
  );

  typedef struct {
    int unsigned at;
    string       name;
    logic [4:0]  v;
  } exp_t;

  exp_t        sb[$];
  int unsigned edge_n = 0;
  int          checks = 0;
  int          errors = 0;

  wire [4:0] obs = {bus.dom_rst_n, bus.dom_clk_en, bus.dom_rdy, bus.busy, bus.rst_flag};

  initial forever begin
    @(posedge clk);
    edge_n++;
  end

  // Monitor: each negedge, compare every entry due at the most recent edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].at <= edge_n) begin
        e = sb.pop_front();
        checks++;
        if (e.at != edge_n) begin
          errors++;
          $display("FAIL %s: expectation for edge %0d not sampled (now edge %0d)", e.name, e.at, edge_n);
        end else if (obs !== e.v) begin
          errors++;
          $display("FAIL %s: edge %0d got %b want %b (rst_n,clk_en,rdy,busy,flag)", e.name, edge_n, obs, e.v);
        end
      end
    end
  end

  task automatic push(input int unsigned at, input string name, input logic [4:0] v);
    exp_t e;
    e.at = at; e.name = name; e.v = v;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic step_to(input int unsigned at);
    while (edge_n < at) @(negedge clk);
  endtask

  function automatic int unsigned nxt();
    return edge_n + 1;
  endfunction

  task automatic expect_seq(input int unsigned e0, input string tag);
    push(e0,      {tag, "_hold_start"},  5'b00011);
    push(e0 + 9,  {tag, "_hold_last"},   5'b00011);
    push(e0 + 10, {tag, "_rst_release"}, 5'b10011);
    push(e0 + 17, {tag, "_wait_last"},   5'b10011);
    push(e0 + 18, {tag, "_run"},         5'b11101);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", edge_n);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned e0, r, s, w, p;
    bus.pwr_rdy = 1'b0; bus.sw_rst_req = 1'b0; bus.stop_req = 1'b0; bus.rst_flag_clr = 1'b0;

    step(1);
    push(nxt(), "reset_state", 5'b00000);
    step(1);
    rst_n = 1'b1;
    push(nxt(), "off_no_pwr", 5'b00000);
    step(1);

    // Power-up with default durations
    bus.pwr_rdy = 1'b1;
    e0 = nxt();
    expect_seq(e0, "pwrup");
    step_to(e0 + 18);

    bus.rst_flag_clr = 1'b1;
    push(nxt(), "flag_clr", 5'b11100);
    step(1);
    bus.rst_flag_clr = 1'b0;

    // Software reset from RUN
    bus.sw_rst_req = 1'b1;
    r = nxt();
    expect_seq(r, "swrst");
    step(1);
    bus.sw_rst_req = 1'b0;
    step_to(r + 18);

    // Stop and wake
    bus.stop_req = 1'b1;
    s = nxt();
    push(s,     "stop_enter", 5'b10001);
    push(s + 3, "stop_hold",  5'b10001);
    step_to(s + 3);
    bus.stop_req = 1'b0;
    w = nxt();
    push(w, "wake", 5'b11101);
    step(1);

    // Restart mid-hold
    bus.pwr_rdy = 1'b0; bus.rst_flag_clr = 1'b1;
    push(nxt(), "pwr_off_clr", 5'b00000);
    step(1);
    bus.rst_flag_clr = 1'b0; bus.pwr_rdy = 1'b1;
    e0 = nxt();
    push(e0, "rs_hold_start", 5'b00011);
    step_to(e0 + 4);
    bus.sw_rst_req = 1'b1;
    push(e0 + 5,  "rs_restart",   5'b00011);
    push(e0 + 10, "rs_no_early",  5'b00011);
    push(e0 + 14, "rs_hold_last", 5'b00011);
    push(e0 + 15, "rs_release",   5'b10011);
    push(e0 + 22, "rs_wait_last", 5'b10011);
    push(e0 + 23, "rs_run",       5'b11101);
    step(1);
    bus.sw_rst_req = 1'b0;
    step_to(e0 + 23);

    // Power loss during CLK_WAIT, then a full sequence on return
    bus.pwr_rdy = 1'b0;
    push(nxt(), "pwr_loss_run", 5'b00001);
    step(1);
    bus.pwr_rdy = 1'b1;
    e0 = nxt();
    push(e0,      "pl_hold_start", 5'b00011);
    push(e0 + 12, "pl_clk_wait",   5'b10011);
    step_to(e0 + 12);
    bus.pwr_rdy = 1'b0;
    push(e0 + 13, "pl_off", 5'b00001);
    step(1);
    bus.pwr_rdy = 1'b1;
    p = nxt();
    expect_seq(p, "pl_return");
    step_to(p + 18);

    // Flag set/clear race, and sw reset beating stop in RUN
    bus.rst_flag_clr = 1'b1;
    push(nxt(), "flag_clr2", 5'b11100);
    step(1);
    bus.sw_rst_req = 1'b1; bus.stop_req = 1'b1;
    r = nxt();
    push(r,      "race_set_wins",   5'b00011);
    push(r + 10, "race_release",    5'b10011);
    push(r + 18, "race_run",        5'b11101);
    push(r + 19, "race_stop_after", 5'b10001);
    step(1);
    bus.sw_rst_req = 1'b0; bus.rst_flag_clr = 1'b0;
    step_to(r + 19);
    bus.stop_req = 1'b0;
    push(nxt(), "wake2", 5'b11101);
    step(1);

    // Asynchronous reset while in CLK_WAIT
    bus.sw_rst_req = 1'b1;
    r = nxt();
    step(1);
    bus.sw_rst_req = 1'b0;
    push(r + 12, "ar_clk_wait", 5'b10011);
    step_to(r + 12);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    push(edge_n, "async_rst", 5'b00000);
    step(1);
    push(nxt(), "rst_held", 5'b00000);
    step(1);
    rst_n = 1'b1;
    push(nxt(), "post_rst_hold", 5'b00011);
    step(1);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      $display("FAIL drain: %0d expectations never sampled, required 0", sb.size());
      errors += sb.size();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rcc_dom_rst_clk_seq.md
Name: rcc_dom_rst_clk_seq

Overview:
- Per-domain reset/clock sequencer for the RCC vcore; one instance per domain (D1, D2, CPU1, CPU2).
- Enforces the power-up and software-reset ordering: hold domain reset for a fixed duration, release it, wait a fixed delay, then enable the domain bus/kernel clock.
- Also handles stop-mode clock gating with state retention, and immediate shutdown on power loss.
- Sits between rcc_sys_clk_rst_ctrl (power-good, stop request) and the register file (software reset request, reset flag).

Parameters:
- RST_DURATION, 10, cycles domain reset is held asserted in RST_HOLD; must be >= 1.
- CLK_ON_DELAY, 8, cycles between reset release and clock enable; must be >= 1.
- CNT_W, 8, counter width; must hold max(RST_DURATION, CLK_ON_DELAY) - 1.

Ports:
- clk, input, 1, sequencer clock (rcc_hclk domain).
- rst_n, input, 1, asynchronous active-low reset.
- pwr_rdy, input, 1, domain power good, already synchronized; level.
- sw_rst_req, input, 1, software domain reset request, single-cycle pulse.
- stop_req, input, 1, domain stop-mode request; level.
- rst_flag_clr, input, 1, clear pulse for rst_flag.
- dom_rst_n, output, 1, domain reset, active-low, registered.
- dom_clk_en, output, 1, domain clock gate enable, registered.
- dom_rdy, output, 1, high in RUN only.
- busy, output, 1, high in RST_HOLD or CLK_WAIT.
- rst_flag, output, 1, sticky flag: a domain reset sequence has started.

Behaviour:
- States: OFF, RST_HOLD, CLK_WAIT, RUN, STOP. Async reset forces OFF, cnt=0, dom_rst_n=0, dom_clk_en=0, dom_rdy=0, busy=0, rst_flag=0.
- All outputs are registered and decoded from the next state, so they change on the same edge as the state.
  - OFF: rst 0, clk_en 0.
  - RST_HOLD: rst 0, clk_en 0, busy 1.
  - CLK_WAIT: rst 1, clk_en 0, busy 1.
  - RUN: rst 1, clk_en 1, rdy 1.
  - STOP: rst 1, clk_en 0.
- Transition priority, evaluated every edge: (1) pwr_rdy==0 forces OFF from any state; (2) sw_rst_req; (3) counter expiry or stop_req.
- OFF: pwr_rdy==1 enters RST_HOLD with cnt=RST_DURATION-1.
- RST_HOLD: decrement cnt. When cnt==0, enter CLK_WAIT with cnt=CLK_ON_DELAY-1. A sw_rst_req here reloads cnt=RST_DURATION-1 (restart).
- CLK_WAIT: decrement cnt. When cnt==0, enter RUN. A sw_rst_req here re-enters RST_HOLD with cnt reloaded.
- RUN: sw_rst_req enters RST_HOLD (reload). Otherwise stop_req==1 enters STOP.
- STOP: sw_rst_req enters RST_HOLD. Otherwise stop_req==0 returns to RUN on the next edge, with no reset and no delay (state retained).
- Resulting durations: dom_rst_n low for exactly RST_DURATION cycles after RST_HOLD entry; dom_clk_en rises exactly CLK_ON_DELAY cycles after dom_rst_n rises.
- rst_flag: set on every RST_HOLD entry, including restarts. rst_flag_clr clears it. Set wins if both occur on the same edge.
- Power loss mid-sequence: OFF on the next edge; dom_rst_n=0 and dom_clk_en=0 on that same edge; cnt=0. No partial outputs.
- sw_rst_req and stop_req together in RUN: reset wins, STOP is not entered. If stop_req is still high after the sequence completes, RUN→STOP on the edge after RUN is entered.
- Counter never wraps: it decrements only in RST_HOLD/CLK_WAIT, and those states exit at 0.

Test Plan:
- Power-up, defaults: pwr_rdy 0→1 sampled at edge E0 → dom_rst_n=0 through edge E9, 1 from E10; dom_clk_en=1 and dom_rdy=1 from E18; busy high E0..E17; rst_flag=1 from E0.
- SW reset in RUN: sw_rst_req pulse at edge R → dom_clk_en=0 and dom_rst_n=0 at R; dom_rst_n=1 at R+10; dom_clk_en=1 at R+18; rst_flag set at R.
- Restart mid-hold: sw_rst_req at edge E0+5 during power-up → dom_rst_n rises at E0+15, not E0+10; dom_clk_en rises at E0+23.
- Stop/wake: stop_req high in RUN at edge S → dom_clk_en=0 at S, dom_rst_n stays 1; stop_req low at edge W → dom_clk_en=1 at W+1? No: dom_clk_en=1 at W, dom_rdy=1 at W; rst_flag unchanged.
- Power loss in CLK_WAIT: pwr_rdy 0 at E0+13 → OFF at E0+13 with dom_rst_n=0 and busy=0; pwr_rdy back at edge P → full 10+8 sequence from P.
- Flag race plus async reset: rst_flag_clr on the same edge as sw_rst_req → rst_flag=1. Assert rst_n mid-CLK_WAIT → all outputs 0 immediately (asynchronously), state OFF.
